// File: rtl/line_window_buffer.sv
// Streaming RGB-to-gray 3x3 window generator for a raster-order frame.
// Optional build macro GRAY_ROUND_EN selects round-to-nearest gray conversion.
module line_window_buffer #(
    parameter int IMG_WIDTH  = 428,
    parameter int IMG_HEIGHT = 428
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        stop,
    input  logic        in_valid,
    input  logic [23:0] in_pixel,
    output logic        in_ready,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [71:0] win,
    output logic        frame_done
);

    localparam int COL_W     = $clog2(IMG_WIDTH);
    localparam int ROW_W     = $clog2(IMG_HEIGHT);
    localparam int WIN_TOTAL = (IMG_HEIGHT - 2) * (IMG_WIDTH - 2);
    localparam int CNT_W     = $clog2(WIN_TOTAL + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_TOTAL - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] win_count;

    logic [7:0] lb0 [0:IMG_WIDTH-1];
    logic [7:0] lb1 [0:IMG_WIDTH-1];
    logic [7:0] tap [0:2][0:2];

    logic [15:0] gray_acc;
    logic [7:0]  gray;
    logic [7:0]  lb_top;
    logic [7:0]  lb_mid;
    logic        accept;
    logic        take;

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;
    assign take     = win_valid && win_ready;
    assign lb_top   = lb0[col];
    assign lb_mid   = lb1[col];

    // Weights sum to 256, so even with the rounding bias the sum stays below 2^16
    // and the shifted result can never exceed 255.
    always_comb begin
        gray_acc = 16'd77  * {8'd0, in_pixel[23:16]}
                 + 16'd150 * {8'd0, in_pixel[15:8]}
                 + 16'd29  * {8'd0, in_pixel[7:0]};
`ifdef GRAY_ROUND_EN
        gray_acc = gray_acc + 16'd128;
`else
        gray_acc = gray_acc + 16'd0;
`endif
        gray = 8'(gray_acc >> 8);
    end

    // NOTE: line buffers and taps carry no reset so they map onto plain RAM/flops;
    // stale contents are never exposed because win_valid is gated by row/col >= 2.
    always_ff @(posedge clk) begin
        if (n_rst && !stop && accept) begin
            lb0[col] <= lb_mid;
            lb1[col] <= gray;
            for (int i = 0; i < 3; i++) begin
                tap[i][0] <= tap[i][1];
                tap[i][1] <= tap[i][2];
            end
            tap[0][2] <= lb_top;
            tap[1][2] <= lb_mid;
            tap[2][2] <= gray;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            col        <= '0;
            row        <= '0;
            win_count  <= '0;
            win_valid  <= 1'b0;
            win        <= '0;
            frame_done <= 1'b0;
        end else if (stop) begin
            col        <= '0;
            row        <= '0;
            win_count  <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (take) begin
                if (win_count == CNT_LAST) begin
                    win_count  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    win_count <= win_count + CNT_W'(1);
                end
            end

            if (accept) begin
                win_valid <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
                win       <= {tap[0][1], tap[0][2], lb_top,
                              tap[1][1], tap[1][2], lb_mid,
                              tap[2][1], tap[2][2], gray};
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end else if (take) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer on a 5x4 frame; gray pixels use R=G=B=k so gray==k.
module tb_line_window_buffer;

    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_pixel = '0;
    logic        in_ready;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic [71:0] win;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int fd_seen = 0;
    int takes = 0;
    int t0, f0;

    line_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .stop       (stop),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win        (win),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_seen <= fd_seen + 1;
        if (n_rst && !stop && win_valid && win_ready) takes <= takes + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[71 - 8 * (3 * i + j) -: 8] = 8'(base + 10 * (r - 2 + i) + (c - 2 + j));
        return w;
    endfunction

    task automatic push_rgb(input logic [23:0] p);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_pixel = p;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check("in_ready_wait", {71'd0, in_ready}, 72'd1);
        step();
    endtask

    task automatic push(input logic [7:0] g);
        push_rgb({g, g, g});
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic stream(input int base, input int first, input int last);
        for (int idx = first; idx <= last; idx++) begin
            int r, c;
            logic v;
            r = idx / W;
            c = idx % W;
            v = (r >= 2) && (c >= 2);
            push(8'(base + 10 * r + c));
            check($sformatf("win_valid_b%0d_p%0d", base, idx), {71'd0, win_valid}, {71'd0, v});
            if (v) check($sformatf("win_b%0d_p%0d", base, idx), win, exp_win(base, r, c));
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        stop = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        n_rst = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset and idle
        n_rst = 1'b0;
        step();
        step();
        check("rst_win_valid", {71'd0, win_valid}, 72'd0);
        check("rst_frame_done", {71'd0, frame_done}, 72'd0);
        check("rst_win", win, 72'd0);
        n_rst = 1'b1;
        step();
        check("idle_in_ready", {71'd0, in_ready}, 72'd1);
        check("idle_win_valid", {71'd0, win_valid}, 72'd0);
        check("idle_frame_done", {71'd0, frame_done}, 72'd0);
        check("idle_win", win, 72'd0);

        // 2: one full frame, consumer always ready
        win_ready = 1'b1;
        t0 = takes;
        f0 = fd_seen;
        stream(0, 0, 12);
        check("first_win_const", win, 72'h0001020a0b0c141516);
        stream(0, 13, 19);
        check("fd_before_last_take", {71'd0, frame_done}, 72'd0);
        idle(1);
        check("fd_pulse", {71'd0, frame_done}, 72'd1);
        check("drain_win_valid", {71'd0, win_valid}, 72'd0);
        idle(1);
        check("fd_single", {71'd0, frame_done}, 72'd0);
        check("f1_windows", 72'(takes - t0), 72'd6);
        check("f1_fd_count", 72'(fd_seen - f0), 72'd1);

        // 3: gray conversion corners (bottom-right byte is the newest gray)
        do_reset();
        push_rgb(24'hFFFFFF);
        check("gray_ffffff", {64'd0, win[7:0]}, 72'h00FF);
        push_rgb(24'h010100);
`ifdef GRAY_ROUND_EN
        check("gray_010100", {64'd0, win[7:0]}, 72'h01);
`else
        check("gray_010100", {64'd0, win[7:0]}, 72'h00);
`endif
        check("gray_shift", {64'd0, win[15:8]}, 72'hFF);
        push_rgb(24'h010101);
        check("gray_010101", {64'd0, win[7:0]}, 72'h01);
        push_rgb(24'h0000FF);
`ifdef GRAY_ROUND_EN
        check("gray_0000ff", {64'd0, win[7:0]}, 72'h1D);
`else
        check("gray_0000ff", {64'd0, win[7:0]}, 72'h1C);
`endif
        idle(1);

        // 4: backpressure on the first window
        do_reset();
        win_ready = 1'b0;
        t0 = takes;
        f0 = fd_seen;
        stream(0, 0, 12);
        in_valid = 1'b1;
        in_pixel = {3{8'd23}};
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bp_in_ready_%0d", i), {71'd0, in_ready}, 72'd0);
            check($sformatf("bp_win_valid_%0d", i), {71'd0, win_valid}, 72'd1);
            check($sformatf("bp_win_%0d", i), win, exp_win(0, 2, 2));
        end
        win_ready = 1'b1;
        step();
        check("bp_resume_valid", {71'd0, win_valid}, 72'd1);
        check("bp_resume_win", win, exp_win(0, 2, 3));
        stream(0, 14, 19);
        idle(2);
        check("bp_windows", 72'(takes - t0), 72'd6);
        check("bp_fd_count", 72'(fd_seen - f0), 72'd1);

        // 5: stop after pixel (2,3), then a fresh frame
        do_reset();
        win_ready = 1'b1;
        stream(0, 0, 13);
        stop = 1'b1;
        in_valid = 1'b1;
        in_pixel = {3{8'd30}};
        step();
        stop = 1'b0;
        in_valid = 1'b0;
        check("stop_win_valid", {71'd0, win_valid}, 72'd0);
        check("stop_frame_done", {71'd0, frame_done}, 72'd0);
        check("stop_in_ready", {71'd0, in_ready}, 72'd1);
        idle(1);
        t0 = takes;
        f0 = fd_seen;
        stream(50, 0, 19);
        idle(2);
        check("stop_windows", 72'(takes - t0), 72'd6);
        check("stop_fd_count", 72'(fd_seen - f0), 72'd1);

        // 6: two back-to-back frames, continuous input
        do_reset();
        t0 = takes;
        f0 = fd_seen;
        stream(0, 0, 19);
        stream(100, 0, 19);
        idle(2);
        check("b2b_windows", 72'(takes - t0), 72'd12);
        check("b2b_fd_count", 72'(fd_seen - f0), 72'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
